// File: rtl/axi4lite_cmd_master.sv
`default_nettype none
// ============================================================================
// Module   : axi4lite_cmd_master
// Brief    : Single-outstanding AXI4-Lite master fed by a cmd/rsp handshake
//            port; returns response, transaction latency and error count.
// Revision : 1.0 - initial release
// ============================================================================
module axi4lite_cmd_master #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LAT_W  = 16,
    parameter int ERR_W  = 8
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [1:0]        rsp_resp,
    output logic [LAT_W-1:0]  rsp_latency,
    output logic [ERR_W-1:0]  err_count,
    output logic [ADDR_W-1:0] m_axi_awaddr,
    output logic              m_axi_awvalid,
    input  logic              m_axi_awready,
    output logic [DATA_W-1:0] m_axi_wdata,
    output logic              m_axi_wvalid,
    input  logic              m_axi_wready,
    input  logic [1:0]        m_axi_bresp,
    input  logic              m_axi_bvalid,
    output logic              m_axi_bready,
    output logic [ADDR_W-1:0] m_axi_araddr,
    output logic              m_axi_arvalid,
    input  logic              m_axi_arready,
    input  logic [DATA_W-1:0] m_axi_rdata,
    input  logic [1:0]        m_axi_rresp,
    input  logic              m_axi_rvalid,
    output logic              m_axi_rready
);

    localparam logic [2:0] c_st_idle    = 3'd0;
    localparam logic [2:0] c_st_wr_aw_w = 3'd1;
    localparam logic [2:0] c_st_wr_b    = 3'd2;
    localparam logic [2:0] c_st_rd_ar   = 3'd3;
    localparam logic [2:0] c_st_rd_r    = 3'd4;
    localparam logic [2:0] c_st_resp    = 3'd5;

    localparam logic [LAT_W-1:0] c_lat_max = '1;
    localparam logic [ERR_W-1:0] c_err_max = '1;

    logic [2:0]        r_state;
    logic              r_aw_done;
    logic              r_w_done;
    logic [LAT_W-1:0]  r_lat;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;

    logic [LAT_W-1:0]  w_lat_inc;
    logic [ERR_W-1:0]  w_err_inc;

    // The handshake cycle itself is counted, so the latched value is r_lat+1.
    assign w_lat_inc = (r_lat == c_lat_max) ? r_lat : r_lat + LAT_W'(1);
    assign w_err_inc = (err_count == c_err_max) ? err_count : err_count + ERR_W'(1);

    assign m_axi_awaddr = r_addr;
    assign m_axi_araddr = r_addr;
    assign m_axi_wdata  = r_wdata;

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state       <= c_st_idle;
            r_aw_done     <= 1'b0;
            r_w_done      <= 1'b0;
            r_lat         <= '0;
            r_addr        <= '0;
            r_wdata       <= '0;
            cmd_ready     <= 1'b1;
            rsp_valid     <= 1'b0;
            rsp_rdata     <= '0;
            rsp_resp      <= 2'b00;
            rsp_latency   <= '0;
            err_count     <= '0;
            m_axi_awvalid <= 1'b0;
            m_axi_wvalid  <= 1'b0;
            m_axi_bready  <= 1'b0;
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready <= 1'b0;
                        r_addr    <= cmd_addr;
                        r_wdata   <= cmd_wdata;
                        r_lat     <= '0;
                        r_aw_done <= 1'b0;
                        r_w_done  <= 1'b0;
                        if (cmd_write) begin
                            m_axi_awvalid <= 1'b1;
                            m_axi_wvalid  <= 1'b1;
                            r_state       <= c_st_wr_aw_w;
                        end else begin
                            m_axi_arvalid <= 1'b1;
                            r_state       <= c_st_rd_ar;
                        end
                    end
                end
                c_st_wr_aw_w: begin
                    r_lat <= w_lat_inc;
                    if (m_axi_awvalid && m_axi_awready) begin
                        m_axi_awvalid <= 1'b0;
                        r_aw_done     <= 1'b1;
                    end
                    if (m_axi_wvalid && m_axi_wready) begin
                        m_axi_wvalid <= 1'b0;
                        r_w_done     <= 1'b1;
                    end
                    // Registered flags: B is opened the cycle after both complete.
                    if (r_aw_done && r_w_done) begin
                        m_axi_bready <= 1'b1;
                        r_state      <= c_st_wr_b;
                    end
                end
                c_st_wr_b: begin
                    r_lat <= w_lat_inc;
                    if (m_axi_bvalid) begin
                        m_axi_bready <= 1'b0;
                        rsp_rdata    <= '0;
                        rsp_resp     <= m_axi_bresp;
                        rsp_latency  <= w_lat_inc;
                        rsp_valid    <= 1'b1;
                        if (m_axi_bresp != 2'b00) begin
                            err_count <= w_err_inc;
                        end
                        r_state <= c_st_resp;
                    end
                end
                c_st_rd_ar: begin
                    r_lat <= w_lat_inc;
                    if (m_axi_arready) begin
                        m_axi_arvalid <= 1'b0;
                        m_axi_rready  <= 1'b1;
                        r_state       <= c_st_rd_r;
                    end
                end
                c_st_rd_r: begin
                    r_lat <= w_lat_inc;
                    if (m_axi_rvalid) begin
                        m_axi_rready <= 1'b0;
                        rsp_rdata    <= m_axi_rdata;
                        rsp_resp     <= m_axi_rresp;
                        rsp_latency  <= w_lat_inc;
                        rsp_valid    <= 1'b1;
                        if (m_axi_rresp != 2'b00) begin
                            err_count <= w_err_inc;
                        end
                        r_state <= c_st_resp;
                    end
                end
                c_st_resp: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        r_state   <= c_st_idle;
                    end
                end
                default: begin
                    m_axi_awvalid <= 1'b0;
                    m_axi_wvalid  <= 1'b0;
                    m_axi_bready  <= 1'b0;
                    m_axi_arvalid <= 1'b0;
                    m_axi_rready  <= 1'b0;
                    rsp_valid     <= 1'b0;
                    cmd_ready     <= 1'b1;
                    r_state       <= c_st_idle;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axi4lite_cmd_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi4lite_cmd_master
// Brief    : Directed self-checking bench with a configurable-wait AXI slave.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi4lite_cmd_master;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int LAT_W  = 16;
    localparam int ERR_W  = 8;

    logic              aclk = 1'b0;
    logic              areset;
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic [1:0]        rsp_resp;
    logic [LAT_W-1:0]  rsp_latency;
    logic [ERR_W-1:0]  err_count;
    logic [ADDR_W-1:0] m_axi_awaddr;
    logic              m_axi_awvalid;
    logic              m_axi_awready;
    logic [DATA_W-1:0] m_axi_wdata;
    logic              m_axi_wvalid;
    logic              m_axi_wready;
    logic [1:0]        m_axi_bresp;
    logic              m_axi_bvalid;
    logic              m_axi_bready;
    logic [ADDR_W-1:0] m_axi_araddr;
    logic              m_axi_arvalid;
    logic              m_axi_arready;
    logic [DATA_W-1:0] m_axi_rdata;
    logic [1:0]        m_axi_rresp;
    logic              m_axi_rvalid;
    logic              m_axi_rready;

    always #5 aclk = ~aclk;

    axi4lite_cmd_master #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .LAT_W  (LAT_W),
        .ERR_W  (ERR_W)
    ) u_dut (
        .aclk          (aclk),
        .areset        (areset),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_write     (cmd_write),
        .cmd_addr      (cmd_addr),
        .cmd_wdata     (cmd_wdata),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_rdata     (rsp_rdata),
        .rsp_resp      (rsp_resp),
        .rsp_latency   (rsp_latency),
        .err_count     (err_count),
        .m_axi_awaddr  (m_axi_awaddr),
        .m_axi_awvalid (m_axi_awvalid),
        .m_axi_awready (m_axi_awready),
        .m_axi_wdata   (m_axi_wdata),
        .m_axi_wvalid  (m_axi_wvalid),
        .m_axi_wready  (m_axi_wready),
        .m_axi_bresp   (m_axi_bresp),
        .m_axi_bvalid  (m_axi_bvalid),
        .m_axi_bready  (m_axi_bready),
        .m_axi_araddr  (m_axi_araddr),
        .m_axi_arvalid (m_axi_arvalid),
        .m_axi_arready (m_axi_arready),
        .m_axi_rdata   (m_axi_rdata),
        .m_axi_rresp   (m_axi_rresp),
        .m_axi_rvalid  (m_axi_rvalid),
        .m_axi_rready  (m_axi_rready)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Slave wait configuration: ready/valid rises after N observed cycles.
    int          aw_wait = 0, w_wait = 0, b_wait = 0, ar_wait = 0, r_wait = 0;
    logic [1:0]  s_bresp = 2'b00, s_rresp = 2'b00;
    logic [31:0] s_rdata = 32'h0;

    int          cyc = 0, aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0;
    int          aw_hi = 0, w_hi = 0, ar_hi = 0, aw_first = 0, w_first = 0;
    logic [31:0] seen_awaddr = 32'h0, seen_wdata = 32'h0, seen_araddr = 32'h0;
    logic        unstable = 1'b0;

    always @(negedge aclk) begin
        cyc++;
        if (m_axi_awvalid) begin
            if (aw_hi == 0) begin
                seen_awaddr = m_axi_awaddr;
                aw_first    = cyc;
            end else if (m_axi_awaddr !== seen_awaddr) unstable = 1'b1;
            aw_hi++;
            m_axi_awready = (aw_cnt >= aw_wait);
            aw_cnt++;
        end else begin
            m_axi_awready = 1'b0;
            aw_cnt        = 0;
        end
        if (m_axi_wvalid) begin
            if (w_hi == 0) begin
                seen_wdata = m_axi_wdata;
                w_first    = cyc;
            end else if (m_axi_wdata !== seen_wdata) unstable = 1'b1;
            w_hi++;
            m_axi_wready = (w_cnt >= w_wait);
            w_cnt++;
        end else begin
            m_axi_wready = 1'b0;
            w_cnt        = 0;
        end
        if (m_axi_arvalid) begin
            if (ar_hi == 0) seen_araddr = m_axi_araddr;
            else if (m_axi_araddr !== seen_araddr) unstable = 1'b1;
            ar_hi++;
            m_axi_arready = (ar_cnt >= ar_wait);
            ar_cnt++;
        end else begin
            m_axi_arready = 1'b0;
            ar_cnt        = 0;
        end
        if (m_axi_bready) begin
            m_axi_bvalid = (b_cnt >= b_wait);
            m_axi_bresp  = s_bresp;
            b_cnt++;
        end else begin
            m_axi_bvalid = 1'b0;
            m_axi_bresp  = 2'b00;
            b_cnt        = 0;
        end
        if (m_axi_rready) begin
            m_axi_rvalid = (r_cnt >= r_wait);
            m_axi_rdata  = s_rdata;
            m_axi_rresp  = s_rresp;
            r_cnt++;
        end else begin
            m_axi_rvalid = 1'b0;
            m_axi_rdata  = 32'h0;
            m_axi_rresp  = 2'b00;
            r_cnt        = 0;
        end
    end

    logic [31:0] got_rdata;
    logic [1:0]  got_resp;
    logic [15:0] got_lat;
    logic        hold_bad;

    task automatic do_cmd(input bit wr, input logic [31:0] addr, input logic [31:0] wd, input int hold);
        int t;
        @(negedge aclk);
        aw_hi     = 0;
        w_hi      = 0;
        ar_hi     = 0;
        unstable  = 1'b0;
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wd;
        @(negedge aclk);
        cmd_valid = 1'b0;
        t = 0;
        while (!rsp_valid && t < 2000) begin
            @(negedge aclk);
            t++;
        end
        if (!rsp_valid) begin
            check_val("rsp_timeout", 64'd0, 64'd1);
            return;
        end
        got_rdata = rsp_rdata;
        got_resp  = rsp_resp;
        got_lat   = rsp_latency;
        hold_bad  = 1'b0;
        for (int i = 0; i < hold; i++) begin
            @(negedge aclk);
            if (rsp_rdata !== got_rdata || rsp_resp !== got_resp || rsp_latency !== got_lat ||
                rsp_valid !== 1'b1 || cmd_ready !== 1'b0 ||
                (m_axi_awvalid | m_axi_wvalid | m_axi_arvalid | m_axi_bready | m_axi_rready) !== 1'b0)
                hold_bad = 1'b1;
        end
        rsp_ready = 1'b1;
        @(negedge aclk);
        rsp_ready = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t;
        areset    = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        rsp_ready = 1'b0;
        repeat (3) @(negedge aclk);
        areset = 1'b0;

        check_val("rst_cmd_ready", cmd_ready, 1);
        check_val("rst_rsp_valid", rsp_valid, 0);
        check_val("rst_axi_ctl", {m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready}, 0);
        check_val("rst_err_count", err_count, 0);
        check_val("rst_rsp_fields", {rsp_rdata, rsp_resp, rsp_latency}, 0);

        // Zero-wait write
        do_cmd(1'b1, 32'h0000_0004, 32'hDEAD_BEEF, 0);
        check_val("wr0_awaddr", seen_awaddr, 32'h4);
        check_val("wr0_wdata", seen_wdata, 32'hDEAD_BEEF);
        check_val("wr0_aw_cycles", aw_hi, 1);
        check_val("wr0_w_cycles", w_hi, 1);
        check_val("wr0_same_cycle", aw_first == w_first, 1);
        check_val("wr0_resp", got_resp, 0);
        check_val("wr0_rdata", got_rdata, 0);
        check_val("wr0_latency", got_lat, 3);
        check_val("wr0_err_count", err_count, 0);
        check_val("wr0_idle_after", {rsp_valid, cmd_ready}, 2'b01);

        // W channel lags AW by 4 cycles
        w_wait = 4;
        do_cmd(1'b1, 32'h0000_0020, 32'hCAFE_F00D, 0);
        w_wait = 0;
        check_val("wr1_aw_cycles", aw_hi, 1);
        check_val("wr1_w_cycles", w_hi, 5);
        check_val("wr1_stable", unstable, 0);
        check_val("wr1_latency", got_lat, 7);
        check_val("wr1_single_rsp", {rsp_valid, cmd_ready}, 2'b01);

        // Read with 3 wait cycles on R
        r_wait  = 3;
        s_rdata = 32'h1234_5678;
        do_cmd(1'b0, 32'h0000_0008, 32'hFFFF_FFFF, 0);
        r_wait = 0;
        check_val("rd0_araddr", seen_araddr, 32'h8);
        check_val("rd0_rdata", got_rdata, 32'h1234_5678);
        check_val("rd0_resp", got_resp, 0);
        check_val("rd0_latency", got_lat, 5);
        check_val("rd0_no_write", aw_hi + w_hi, 0);

        // Response back-pressure for 10 cycles
        r_wait  = 1;
        s_rdata = 32'hAABB_CCDD;
        do_cmd(1'b0, 32'h0000_000C, 32'h0, 10);
        r_wait = 0;
        check_val("hold_stable", hold_bad, 0);
        check_val("hold_rdata", got_rdata, 32'hAABB_CCDD);
        check_val("hold_latency", got_lat, 3);
        check_val("hold_err_count", err_count, 0);

        // Error responses, then saturation of the error counter
        s_rresp = 2'b10;
        s_rdata = 32'h0BAD_0BAD;
        do_cmd(1'b0, 32'h0000_0010, 32'h0, 0);
        check_val("err1_resp", got_resp, 2);
        check_val("err1_count", err_count, 1);
        s_bresp = 2'b11;
        for (int i = 2; i <= 300; i++) begin
            do_cmd(i[0] == 1'b0, 32'h0000_0100, i, 0);
            if (i == 2) check_val("err2_write_resp", got_resp, 3);
            if (i == 254) check_val("err254_count", err_count, 254);
            if (i == 256) check_val("err256_count", err_count, 255);
        end
        check_val("err300_count", err_count, 255);
        s_bresp = 2'b00;
        s_rresp = 2'b00;

        // Reset while waiting on B
        b_wait = 1000;
        @(negedge aclk);
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 32'h0000_0040;
        cmd_wdata = 32'h0000_0077;
        @(negedge aclk);
        cmd_valid = 1'b0;
        t = 0;
        while (!m_axi_bready && t < 50) begin
            @(negedge aclk);
            t++;
        end
        check_val("rst_mid_in_wr_b", m_axi_bready, 1);
        areset = 1'b1;
        @(negedge aclk);
        areset = 1'b0;
        b_wait = 0;
        check_val("rst_mid_axi_ctl", {m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready}, 0);
        check_val("rst_mid_cmd_ready", cmd_ready, 1);
        check_val("rst_mid_rsp_valid", rsp_valid, 0);
        check_val("rst_mid_err_count", err_count, 0);
        hold_bad = 1'b0;
        repeat (5) begin
            @(negedge aclk);
            if (rsp_valid !== 1'b0) hold_bad = 1'b1;
        end
        check_val("rst_mid_no_rsp", hold_bad, 0);

        s_rdata = 32'h0000_55AA;
        do_cmd(1'b0, 32'h0000_0044, 32'h0, 0);
        check_val("post_rst_araddr", seen_araddr, 32'h44);
        check_val("post_rst_rdata", got_rdata, 32'h0000_55AA);
        check_val("post_rst_latency", got_lat, 2);
        check_val("post_rst_err_count", err_count, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/axi4lite_cmd_master.md
Name: axi4lite_cmd_master

Overview:
- Single-outstanding AXI4-Lite master that converts a simple request/response command port into AXI4-Lite write and read transactions.
- Sits directly upstream of axi4lite_slave and drives its AW/W/B/AR/R channels.
- Replaces the VIP master in self-contained firmware-style tests and integration.
- Reports the response, the transaction latency and a running error count.

Parameters:
- ADDR_W, 32, AXI address width.
- DATA_W, 32, AXI data width.
- LAT_W, 16, latency counter width (saturating).
- ERR_W, 8, error counter width (saturating).

Ports:
- aclk  in  1  clock.
- areset  in  1  synchronous active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_W  target address.
- cmd_wdata  in  DATA_W  write data (ignored for reads).
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready.
- rsp_rdata  out  DATA_W  read data (0 for writes).
- rsp_resp  out  2  BRESP or RRESP.
- rsp_latency  out  LAT_W  cycles from command accept to B/R handshake.
- err_count  out  ERR_W  count of non-OKAY responses.
- m_axi_awaddr/awvalid/awready, wdata/wvalid/wready, bresp/bvalid/bready, araddr/arvalid/arready, rdata/rresp/rvalid/rready: standard AXI4-Lite master-side channels. No WSTRB or PROT.

Behaviour:
- Clocking and reset:
  - One clock, aclk; reset is synchronous and active-high (areset).
  - On reset, all outputs are 0 except cmd_ready=1, and the FSM is in IDLE.
  - Reset mid-transaction abandons it immediately: VALIDs drop the next edge, and no response is produced.
- FSM states: IDLE, WR_AW_W, WR_B, RD_AR, RD_R, RESP.
- IDLE:
  - cmd_ready=1, and only in IDLE.
  - On accept, cmd_addr and cmd_wdata are registered and the latency counter is cleared to 0.
  - Write goes to WR_AW_W; read goes to RD_AR.
- WR_AW_W:
  - awvalid and wvalid are both 1 from the cycle after accept.
  - Each VALID drops the cycle after its own handshake; per-channel done flags are kept.
  - AW and W may complete in either order or in the same cycle.
  - Address and data stay stable while VALID is high.
  - Move to WR_B the cycle after both are done.
- WR_B:
  - bready=1.
  - On bvalid: capture bresp, set rsp_rdata=0, go to RESP.
- RD_AR:
  - arvalid=1 until arready, then go to RD_R.
- RD_R:
  - rready=1.
  - On rvalid: capture rdata and rresp, go to RESP.
- RESP:
  - rsp_valid=1; rsp_* are held stable until rsp_ready.
  - On handshake, go to IDLE. cmd_ready rises the following cycle, so there are no back-to-back accepts.
- Latency counter:
  - Increments every cycle in WR_AW_W, WR_B, RD_AR and RD_R.
  - Saturates at 2^LAT_W-1.
  - Latched into rsp_latency at the B/R handshake, counting the handshake cycle.
  - Minimum value is 3 for a write with zero-wait slave readies, and 2 for a read.
- err_count:
  - +1 at each B/R handshake with resp != 2'b00.
  - Saturates at 2^ERR_W-1; cleared only by reset.
- No combinational path from any AXI input to any AXI output. All VALID/READY outputs are registered.

Test Plan:
- Write 0x0000_0004 ← 0xDEAD_BEEF with slave ready=1 and OKAY → awaddr=0x4, wdata=0xDEADBEEF asserted together for one cycle; rsp_resp=0, rsp_latency=3, err_count=0.
- Write where wready lags awready by 4 cycles → awvalid drops after 1 cycle, wvalid held 5 cycles with data stable; one response with rsp_latency=7.
- Read 0x8 with slave returning 0x1234_5678 and RRESP=0 after 3 wait cycles on rvalid → rsp_rdata=0x12345678, rsp_resp=0, rsp_latency=5.
- Read returning SLVERR (2) → rsp_resp=2, err_count=1; repeat 300 errors with ERR_W=8 → err_count saturates at 255.
- Hold rsp_ready=0 for 10 cycles → rsp_* stable, cmd_ready=0 throughout, no AXI activity.
- Assert areset during WR_B with bvalid=0 → next cycle all VALIDs=0, cmd_ready=1, rsp_valid=0, err_count=0; a subsequent read completes normally.
